button_platform_ctrl: RTL and testbench

Controller that sequences the button-driven moving platform in the game level.
- Each frame it checks whether either player's feet overlap the purple or the yellow floor button.
- It latches per-button "pushed" flags. These feed the button sprite modules' is_button_push inputs, which hide the raised sprite.
- It moves a shared platform between a raised and a lowered Y position, with a release hold-off.
- It sits between the player motion modules and the color mapper / collision logic.

---
 rtl/game_pkg.sv | 27 ++
 rtl/button_hit_detect.sv | 26 ++
 rtl/button_platform_ctrl.sv | 127 ++++++++++++
 tb/tb_button_platform_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-level types and constants: platform FSM states, button geometry, screen size.
package game_pkg;

  typedef enum logic [1:0] {
    UP       = 2'd0,
    LOWERING = 2'd1,
    DOWN     = 2'd2,
    RAISING  = 2'd3
  } plat_state_t;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned CALC_W  = COORD_W + 1;
  localparam int unsigned HOLD_W  = 6;

  // Button placement and size, also used by the button sprite modules
  localparam int unsigned BUTTON_P_X      = 172;
  localparam int unsigned BUTTON_P_Y      = 241;
  localparam int unsigned BUTTON_Y_X      = 142;
  localparam int unsigned BUTTON_Y_Y      = 322;
  localparam int unsigned BUTTON_W        = 20;
  localparam int unsigned BUTTON_H        = 10;
  localparam int unsigned BUTTON_FOOT_TOL = 3;

endpackage

// File: rtl/button_hit_detect.sv
// Combinational test of one player foot point against one button box (with foot tolerance above it).
module button_hit_detect
  import game_pkg::*;
#(
  parameter int unsigned bx  = BUTTON_P_X,
  parameter int unsigned by  = BUTTON_P_Y,
  parameter int unsigned w   = BUTTON_W,
  parameter int unsigned h   = BUTTON_H,
  parameter int unsigned tol = BUTTON_FOOT_TOL
) (
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic               hit
);

  logic [CALC_W-1:0] x_e;
  logic [CALC_W-1:0] y_e;

  assign x_e = CALC_W'(x);
  assign y_e = CALC_W'(y);

  // Tolerance is added to y rather than subtracted from by, so a button near the top row cannot underflow
  assign hit = (x_e >= CALC_W'(bx)) && (x_e < CALC_W'(bx + w)) &&
               ((y_e + CALC_W'(tol)) >= CALC_W'(by)) && (y_e < CALC_W'(by + h));

endmodule

// File: rtl/button_platform_ctrl.sv
// Latches per-button pressed flags and moves the shared platform between its raised and lowered
// positions once per frame tick, holding it down for a while after both buttons are released.
module button_platform_ctrl
  import game_pkg::*;
#(
  parameter int unsigned BTN_P_X     = BUTTON_P_X,
  parameter int unsigned BTN_P_Y     = BUTTON_P_Y,
  parameter int unsigned BTN_Y_X     = BUTTON_Y_X,
  parameter int unsigned BTN_Y_Y     = BUTTON_Y_Y,
  parameter int unsigned BTN_W       = BUTTON_W,
  parameter int unsigned BTN_H       = BUTTON_H,
  parameter int unsigned FOOT_TOL    = BUTTON_FOOT_TOL,
  parameter int unsigned PLAT_UP_Y   = 300,
  parameter int unsigned PLAT_DOWN_Y = 360,
  parameter int unsigned STEP        = 2,
  parameter int unsigned HOLD_FRAMES = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic [COORD_W-1:0] fire_x,
  input  logic [COORD_W-1:0] fire_y,
  input  logic [COORD_W-1:0] water_x,
  input  logic [COORD_W-1:0] water_y,
  output logic               is_button_push,
  output logic               is_button_yellow_push,
  output logic [COORD_W-1:0] platform_y,
  output logic               platform_moving,
  output plat_state_t        plat_state
);

  localparam logic [CALC_W-1:0] UP_Y_E   = CALC_W'(PLAT_UP_Y);
  localparam logic [CALC_W-1:0] DOWN_Y_E = CALC_W'(PLAT_DOWN_Y);

  logic               frame_clk_d;
  logic               tick_c;
  logic               fire_hit_p, fire_hit_y, water_hit_p, water_hit_y;
  logic               hit_p, hit_y, press, active;
  logic [HOLD_W-1:0]  hold_cnt, hold_n;
  logic [COORD_W-1:0] plat_y_n;
  logic [CALC_W-1:0]  lower_sum, raise_diff;
  plat_state_t        state_n;

  button_hit_detect #(.bx(BTN_P_X), .by(BTN_P_Y), .w(BTN_W), .h(BTN_H), .tol(FOOT_TOL))
    u_fire_p  (.x(fire_x),  .y(fire_y),  .hit(fire_hit_p));
  button_hit_detect #(.bx(BTN_Y_X), .by(BTN_Y_Y), .w(BTN_W), .h(BTN_H), .tol(FOOT_TOL))
    u_fire_y  (.x(fire_x),  .y(fire_y),  .hit(fire_hit_y));
  button_hit_detect #(.bx(BTN_P_X), .by(BTN_P_Y), .w(BTN_W), .h(BTN_H), .tol(FOOT_TOL))
    u_water_p (.x(water_x), .y(water_y), .hit(water_hit_p));
  button_hit_detect #(.bx(BTN_Y_X), .by(BTN_Y_Y), .w(BTN_W), .h(BTN_H), .tol(FOOT_TOL))
    u_water_y (.x(water_x), .y(water_y), .hit(water_hit_y));

  assign tick_c     = frame_clk & ~frame_clk_d;
  assign hit_p      = fire_hit_p | water_hit_p;
  assign hit_y      = fire_hit_y | water_hit_y;
  assign press      = hit_p | hit_y;
  assign active     = press | (hold_cnt != '0);
  assign lower_sum  = CALC_W'(platform_y) + CALC_W'(STEP);
  assign raise_diff = CALC_W'(platform_y) - CALC_W'(STEP);

  // Next-state, platform position and hold counter; everything holds between ticks
  always_comb begin
    state_n  = plat_state;
    plat_y_n = platform_y;
    hold_n   = hold_cnt;
    if (tick_c) begin
      if (press) begin
        hold_n = HOLD_W'(HOLD_FRAMES);
      end else if (hold_cnt != '0) begin
        hold_n = hold_cnt - HOLD_W'(1);
      end
      unique case (plat_state)
        UP: begin
          if (active) state_n = LOWERING;
        end
        LOWERING: begin
          if (!active) begin
            state_n = RAISING;
          end else if (lower_sum >= DOWN_Y_E) begin
            plat_y_n = COORD_W'(PLAT_DOWN_Y);
            state_n  = DOWN;
          end else begin
            plat_y_n = lower_sum[COORD_W-1:0];
          end
        end
        DOWN: begin
          if (!active) state_n = RAISING;
        end
        RAISING: begin
          // A new press beats arrival at the top
          if (active) begin
            state_n = LOWERING;
          end else if (raise_diff[CALC_W-1] || (raise_diff <= UP_Y_E)) begin
            plat_y_n = COORD_W'(PLAT_UP_Y);
            state_n  = UP;
          end else begin
            plat_y_n = raise_diff[COORD_W-1:0];
          end
        end
        default: state_n = UP;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_clk_d           <= 1'b0;
      plat_state            <= UP;
      platform_y            <= COORD_W'(PLAT_UP_Y);
      hold_cnt              <= '0;
      platform_moving       <= 1'b0;
      is_button_push        <= 1'b0;
      is_button_yellow_push <= 1'b0;
    end else begin
      frame_clk_d     <= frame_clk;
      plat_state      <= state_n;
      platform_y      <= plat_y_n;
      hold_cnt        <= hold_n;
      platform_moving <= (state_n == LOWERING) || (state_n == RAISING);
      if (tick_c) begin
        is_button_push        <= hit_p;
        is_button_yellow_push <= hit_y;
      end
    end
  end

endmodule

// File: tb/tb_button_platform_ctrl.sv
// Directed bench for button_platform_ctrl: hit-box vector table plus platform motion sequences.
module tb_button_platform_ctrl;
  import game_pkg::*;

  typedef struct {
    logic [9:0] fx, fy, wx, wy;
    logic       exp_p, exp_y;
  } hit_vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [9:0] fire_x = '0, fire_y = '0, water_x = '0, water_y = '0;

  logic        push_p, push_y, moving;
  logic [9:0]  plat_y;
  plat_state_t st;
  logic        push_p7, push_y7, moving7;
  logic [9:0]  plat_y7;
  plat_state_t st7;

  int n_checks = 0;
  int n_fail   = 0;
  hit_vec_t vecs[14];

  always #5 clk = ~clk;

  button_platform_ctrl dut (
    .Clk(clk), .Reset(reset), .frame_clk(frame_clk),
    .fire_x(fire_x), .fire_y(fire_y), .water_x(water_x), .water_y(water_y),
    .is_button_push(push_p), .is_button_yellow_push(push_y),
    .platform_y(plat_y), .platform_moving(moving), .plat_state(st)
  );

  button_platform_ctrl #(.STEP(7)) dut7 (
    .Clk(clk), .Reset(reset), .frame_clk(frame_clk),
    .fire_x(fire_x), .fire_y(fire_y), .water_x(water_x), .water_y(water_y),
    .is_button_push(push_p7), .is_button_yellow_push(push_y7),
    .platform_y(plat_y7), .platform_moving(moving7), .plat_state(st7)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_plat(input string tag, input int exp_st, input int exp_y, input int exp_mv);
    check({tag, " state"},  int'(st), exp_st);
    check({tag, " y"},      int'(plat_y), exp_y);
    check({tag, " moving"}, int'(moving), exp_mv);
  endtask

  task automatic check_plat7(input string tag, input int exp_st, input int exp_y, input int exp_mv);
    check({tag, " state"},  int'(st7), exp_st);
    check({tag, " y"},      int'(plat_y7), exp_y);
    check({tag, " moving"}, int'(moving7), exp_mv);
  endtask

  // One frame_clk pulse; outputs sampled on a falling Clk edge afterwards
  task automatic do_tick();
    @(negedge clk); frame_clk = 1'b1;
    @(negedge clk); frame_clk = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_pos(input int fx, input int fy, input int wx, input int wy);
    fire_x = 10'(fx); fire_y = 10'(fy); water_x = 10'(wx); water_y = 10'(wy);
  endtask

  task automatic reset_check(input string tag, input int cycles);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      frame_clk = ~frame_clk;
    end
    check_plat(tag, int'(UP), 300, 0);
    check({tag, " push_p"}, int'(push_p), 0);
    check({tag, " push_y"}, int'(push_y), 0);
    reset = 1'b0;
    frame_clk = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{10'd0,   10'd0,   10'd0,   10'd0,   1'b0, 1'b0};
    vecs[1]  = '{10'd180, 10'd243, 10'd0,   10'd0,   1'b1, 1'b0};
    vecs[2]  = '{10'd172, 10'd238, 10'd0,   10'd0,   1'b1, 1'b0};
    vecs[3]  = '{10'd191, 10'd250, 10'd0,   10'd0,   1'b1, 1'b0};
    vecs[4]  = '{10'd171, 10'd243, 10'd0,   10'd0,   1'b0, 1'b0};
    vecs[5]  = '{10'd192, 10'd243, 10'd0,   10'd0,   1'b0, 1'b0};
    vecs[6]  = '{10'd180, 10'd237, 10'd0,   10'd0,   1'b0, 1'b0};
    vecs[7]  = '{10'd180, 10'd251, 10'd0,   10'd0,   1'b0, 1'b0};
    vecs[8]  = '{10'd0,   10'd0,   10'd150, 10'd320, 1'b0, 1'b1};
    vecs[9]  = '{10'd0,   10'd0,   10'd161, 10'd331, 1'b0, 1'b1};
    vecs[10] = '{10'd0,   10'd0,   10'd162, 10'd325, 1'b0, 1'b0};
    vecs[11] = '{10'd180, 10'd243, 10'd150, 10'd320, 1'b1, 1'b1};
    vecs[12] = '{10'd150, 10'd320, 10'd150, 10'd331, 1'b0, 1'b1};
    vecs[13] = '{10'd142, 10'd319, 10'd172, 10'd241, 1'b1, 1'b1};

    // Reset with frame_clk toggling, then idle frames
    reset_check("rst1", 3);
    for (int i = 0; i < 20; i++) do_tick();
    check_plat("idle20", int'(UP), 300, 0);

    // Hit-box boundaries, one tick per vector
    for (int i = 0; i < 14; i++) begin
      set_pos(int'(vecs[i].fx), int'(vecs[i].fy), int'(vecs[i].wx), int'(vecs[i].wy));
      do_tick();
      check($sformatf("vec%0d push_p", i), int'(push_p), int'(vecs[i].exp_p));
      check($sformatf("vec%0d push_y", i), int'(push_y), int'(vecs[i].exp_y));
    end

    set_pos(0, 0, 0, 0);
    reset_check("rst2", 2);

    // Fire on purple: one tick to LOWERING, then 30 moves to 360
    set_pos(180, 243, 0, 0);
    do_tick();
    check("press push_p", int'(push_p), 1);
    check_plat("press", int'(LOWERING), 300, 1);
    for (int i = 1; i <= 30; i++) begin
      do_tick();
      check($sformatf("lower%0d y", i), int'(plat_y), 300 + 2 * i);
      check($sformatf("lower%0d state", i), int'(st), (i == 30) ? int'(DOWN) : int'(LOWERING));
    end
    check("down moving", int'(moving), 0);

    // Release: held DOWN for 8 ticks, RAISING on the 9th, back at 300 after 30 more
    set_pos(0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      do_tick();
      check_plat($sformatf("hold%0d", i), int'(DOWN), 360, 0);
    end
    check("release push_p", int'(push_p), 0);
    do_tick();
    check_plat("hold9", int'(RAISING), 360, 1);
    for (int i = 1; i <= 30; i++) begin
      do_tick();
      check($sformatf("raise%0d y", i), int'(plat_y), 360 - 2 * i);
    end
    check_plat("raised", int'(UP), 300, 0);

    // Lower again, release, raise to 330, then re-press
    set_pos(180, 243, 0, 0);
    for (int i = 0; i < 31; i++) do_tick();
    check_plat("down2", int'(DOWN), 360, 0);
    set_pos(0, 0, 0, 0);
    for (int i = 0; i < 9 + 15; i++) do_tick();
    check_plat("raise330", int'(RAISING), 330, 1);
    set_pos(180, 243, 0, 0);
    do_tick();
    check_plat("repress", int'(LOWERING), 330, 1);
    do_tick();
    check_plat("repress+1", int'(LOWERING), 332, 1);
    do_tick();
    check_plat("repress+2", int'(LOWERING), 334, 1);
    for (int i = 0; i < 3; i++) do_tick();
    check_plat("at340", int'(LOWERING), 340, 1);

    // Single-cycle reset mid-descent snaps back and clears the hold counter
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_plat("midrst", int'(UP), 300, 0);
    check("midrst push_p", int'(push_p), 0);
    reset = 1'b0;
    set_pos(0, 0, 0, 0);
    do_tick();
    check_plat("midrst idle", int'(UP), 300, 0);

    // Both players on both buttons, STEP=7 saturating at the bottom
    set_pos(180, 243, 150, 320);
    do_tick();
    check("both push_p", int'(push_p7), 1);
    check("both push_y", int'(push_y7), 1);
    check_plat7("both", int'(LOWERING), 300, 1);
    for (int i = 1; i <= 9; i++) begin
      do_tick();
      check($sformatf("s7 lower%0d y", i), int'(plat_y7), (i == 9) ? 360 : 300 + 7 * i);
    end
    check_plat7("s7 down", int'(DOWN), 360, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
